// File: rtl/bridge_pkg.sv
// Shared types and helpers for the FIFO-bridge write-side blocks.
package bridge_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating-priority encoder: first set bit of req searching ptr, ptr+1, ... modulo N.
module rr_priority_picker
    import bridge_pkg::*;
#(
    parameter int N = 3,
    parameter int W = id_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [2*N-1:0] doubled;
    logic [2*N-1:0] rotated;
    logic [W:0]     sum;

    assign doubled = {req, req};
    assign rotated = doubled >> ptr;

    // NOTE: every output gets a default before the loop; a path that skips an assignment would infer a latch.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (W+1)'(k);
                if (sum >= (W+1)'(N)) begin
                    sum = sum - (W+1)'(N);
                end
                idx = sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one async-FIFO write port among NUM_REQ byte producers.
module fifo_wr_arbiter
    import bridge_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int NUM_REQ      = 3,
    parameter int MAX_BURST    = 4,
    parameter int IDLE_TIMEOUT = 16,
    localparam int ID_W        = id_width(NUM_REQ)
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wr_full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    arb_state_t          state, state_n;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_n;
    logic [ID_W-1:0]     grant_id_n;
    logic [BEAT_W-1:0]   beat_cnt, beat_cnt_n;
    logic [IDLE_W-1:0]   idle_cnt, idle_cnt_n;

    logic                pick_found;
    logic [ID_W-1:0]     pick_idx;
    logic                g_valid;
    logic                g_last;
    logic                release_grant;
    logic [ID_W-1:0]     next_ptr;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_priority_picker #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign g_valid  = req_valid[grant_id];
    assign g_last   = req_last[grant_id];
    assign busy     = (state == BURST);
    // Explicit wrap so a non-power-of-two requester count never lands on an unused index.
    assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        state_n       = state;
        rr_ptr_n      = rr_ptr;
        grant_id_n    = grant_id;
        beat_cnt_n    = beat_cnt;
        idle_cnt_n    = idle_cnt;
        req_ready     = '0;
        wr_en         = 1'b0;
        wr_data       = '0;
        release_grant = 1'b0;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_id_n = pick_idx;
                    beat_cnt_n = '0;
                    idle_cnt_n = '0;
                    state_n    = BURST;
                end
            end
            BURST: begin
                req_ready[grant_id] = !wr_full;
                // A valid byte blocked by wr_full neither advances nor idles the grant.
                if (g_valid && !wr_full) begin
                    wr_en         = 1'b1;
                    wr_data       = data_arr[grant_id];
                    beat_cnt_n    = beat_cnt + 1'b1;
                    idle_cnt_n    = '0;
                    release_grant = g_last || (beat_cnt == BEAT_W'(MAX_BURST - 1));
                end else if (!g_valid) begin
                    idle_cnt_n    = idle_cnt + 1'b1;
                    release_grant = (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));
                end
                if (release_grant) begin
                    state_n  = IDLE;
                    rr_ptr_n = next_ptr;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_ptr_n;
            grant_id <= grant_id_n;
            beat_cnt <= beat_cnt_n;
            idle_cnt <= idle_cnt_n;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios then random traffic against a queue-based model.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int N  = 3;
    localparam int MB = 4;
    localparam int TO = 16;
    localparam int IW = 2;

    logic            wr_clk = 1'b0;
    logic            wr_rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            wr_full;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic [IW-1:0]   grant_id;
    logic            busy;

    fifo_wr_arbiter #(
        .DATA_WIDTH   (DW),
        .NUM_REQ      (N),
        .MAX_BURST    (MB),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .wr_clk    (wr_clk),
        .wr_rst    (wr_rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wr_full   (wr_full),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } wr_rec_t;

    beat_t      src_q [N][$];
    wr_rec_t    wlog[$];
    logic [7:0] exp_q[$];
    logic [N-1:0] en;
    logic       full_drv;
    int         cyc;
    int         n_checks;
    int         n_fail;
    int         tot_pushed;

    // Reference model: who owns the port, where the search starts, beats and idle cycles so far.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_beats;
    int m_idle;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_beats = 0;
        m_idle  = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = en[i] && (src_q[i].size() > 0);
            req_data[i*DW +: DW]   = (src_q[i].size() > 0) ? src_q[i][0].data : 8'h00;
            req_last[i]            = (src_q[i].size() > 0) ? src_q[i][0].last : 1'b0;
        end
        wr_full = full_drv;
    endtask

    task automatic tick();
        bit           acc;
        bit           lst;
        bit           found;
        int           o;
        logic [N-1:0] exp_ready;
        logic [7:0]   exp_data;
        drive();
        #1;
        o         = m_owner;
        acc       = m_busy && !full_drv && req_valid[o];
        exp_ready = (m_busy && !full_drv) ? (N'(1) << o) : '0;
        exp_data  = acc ? src_q[o][0].data : 8'h00;
        check("busy", 32'(busy), 32'(m_busy));
        check("grant_id", 32'(grant_id), 32'(o));
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("wr_en", 32'(wr_en), 32'(acc));
        check("wr_data", 32'(wr_data), 32'(exp_data));
        if (wr_en) wlog.push_back('{wr_data, cyc});

        if (!m_busy) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req_valid[(m_ptr + k) % N]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % N;
                    m_busy  = 1;
                    m_beats = 0;
                    m_idle  = 0;
                end
            end
        end else if (acc) begin
            lst = src_q[o][0].last;
            void'(src_q[o].pop_front());
            m_beats++;
            m_idle = 0;
            if (lst || m_beats == MB) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end
        end else if (!req_valid[o]) begin
            m_idle++;
            if (m_idle == TO) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end
        end
        cyc++;
        @(negedge wr_clk);
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 0;
        return 1;
    endfunction

    task automatic run_until_idle(input string tag, input int budget);
        int t = 0;
        while (!(queues_empty() && busy === 1'b0) && t < budget) begin
            tick();
            t++;
        end
        check({tag, "_drain_in_budget"}, 32'(t < budget), 32'd1);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_count"}, 32'(wlog.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < wlog.size(); k++) begin
            check({tag, "_byte"}, 32'(wlog[k].data), 32'(exp_q[k]));
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        src_q[r].push_back('{d, l});
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; tot_pushed = 0;
        en = '1; full_drv = 1'b0;
        model_reset();
        wr_rst = 1'b1;
        drive();
        @(negedge wr_clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        @(negedge wr_clk);
        wr_rst = 1'b0;

        // Round robin: everyone valid, every beat last -> grants 0,1,2,0, one dead cycle between.
        wlog.delete();
        push(0, 8'h01, 1); push(0, 8'h04, 1);
        push(1, 8'h02, 1);
        push(2, 8'h03, 1);
        run_until_idle("rr", 40);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_log("rr");
        for (int k = 0; k + 1 < wlog.size(); k++) begin
            check("rr_gap", 32'(wlog[k+1].cyc - wlog[k].cyc), 32'd2);
        end

        // Burst cap: req 0 streams eight bytes without last, req 1 slips in after four.
        wlog.delete();
        for (int b = 0; b < 8; b++) push(0, 8'(8'h10 + b), 0);
        tick();
        push(1, 8'hA0, 1);
        run_until_idle("cap", 60);
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hA0, 8'h14, 8'h15, 8'h16, 8'h17};
        check_log("cap");

        // Back-pressure: wr_full for five cycles while req 2 holds byte 0x55.
        wlog.delete();
        push(2, 8'h54, 0); push(2, 8'h55, 1);
        tick();
        tick();
        full_drv = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive();
            #1;
            check("bp_wr_en_low", 32'(wr_en), 32'd0);
            check("bp_grant_held", 32'(busy), 32'd1);
            #1;
            tick();
        end
        full_drv = 1'b0;
        run_until_idle("bp", 20);
        exp_q = '{8'h54, 8'h55};
        check_log("bp");

        // Idle timeout: req 1 granted then silent for IDLE_TIMEOUT cycles; req 2 waits.
        wlog.delete();
        push(1, 8'h31, 0);
        push(2, 8'h32, 1);
        tick();
        en[1] = 1'b0;
        for (int k = 0; k < TO; k++) begin
            drive();
            #1;
            check("to_still_busy", 32'(busy), 32'd1);
            tick();
        end
        drive();
        #1;
        check("to_released", 32'(busy), 32'd0);
        tick();
        drive();
        #1;
        check("to_next_grant", 32'(grant_id), 32'd2);
        check("to_next_write", 32'(wr_en), 32'd1);
        tick();
        src_q[1].delete();
        en[1] = 1'b1;
        run_until_idle("to", 20);
        exp_q = '{8'h32};
        check_log("to");

        // Wrap from index 2 back to 0 with only req 2 valid.
        wlog.delete();
        push(2, 8'h61, 1); push(2, 8'h62, 1);
        run_until_idle("wrap", 20);
        exp_q = '{8'h61, 8'h62};
        check_log("wrap");
        if (wlog.size() == 2) check("wrap_gap", 32'(wlog[1].cyc - wlog[0].cyc), 32'd2);

        // Reset mid-burst: req 1 at its second beat.
        wlog.delete();
        for (int b = 0; b < 4; b++) push(1, 8'(8'h71 + b), 0);
        tick();
        tick();
        drive();
        wr_rst = 1'b1;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_wr_data", 32'(wr_data), 32'd0);
        model_reset();
        @(negedge wr_clk);
        wr_rst = 1'b0;
        cyc++;
        push(0, 8'h81, 1);
        tick();
        drive();
        #1;
        check("post_rst_grant", 32'(grant_id), 32'd0);
        tick();
        run_until_idle("rst", 60);
        exp_q = '{8'h71, 8'h81, 8'h72, 8'h73, 8'h74};
        check_log("rst");

        // Random traffic with gaps and back-pressure.
        wlog.delete();
        tot_pushed = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    int len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) begin
                        push(i, 8'($urandom), (b == len - 1) ? 1'($urandom_range(0, 1)) : 1'b0);
                        tot_pushed++;
                    end
                end
                en[i] = ($urandom_range(0, 7) != 0);
            end
            full_drv = ($urandom_range(0, 4) == 0);
            tick();
        end
        en = '1;
        full_drv = 1'b0;
        run_until_idle("rand", 300);
        check("rand_total_bytes", 32'(wlog.size()), 32'(tot_pushed));

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
